// File: rtl/char_row_sequencer.sv
// rtl/char_row_sequencer.sv - glyph row fetch and pixel serializer with one-deep request queue
// Build option: define CHAR_SCALE2_EN to hold every pixel for two cycles.
module char_row_sequencer #(
  parameter int ROM_LATENCY = 1
) (
  input  logic       pixelClk,
  input  logic       reset,
  input  logic       inStart,
  input  logic [1:0] inGlyph,
  input  logic [3:0] inRow,
  output logic [5:0] outRomAddress,
  input  logic [7:0] inRomData,
  output logic       outPixel,
  output logic       outPixelValid,
  output logic       outLast,
  output logic       outBusy,
  output logic       outReady,
  output logic       outOverflow
);

`ifdef CHAR_SCALE2_EN
  localparam logic [3:0] LAST_CNT     = 4'd15;
  localparam logic [3:0] LAST_PIX_CNT = 4'd14;
`else
  localparam logic [3:0] LAST_CNT     = 4'd7;
  localparam logic [3:0] LAST_PIX_CNT = 4'd7;
`endif
  localparam logic [1:0] LAST_WAIT = 2'(ROM_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, SHIFT} state_t;

  state_t     state, stateNext;
  logic [5:0] romAddr, romAddrNext;
  logic [5:0] pendAddr, pendAddrNext;
  logic       pendValid, pendValidNext;
  logic       overflow, overflowNext;
  logic [7:0] shiftReg, shiftRegNext;
  logic [3:0] pixCnt, pixCntNext;
  logic [1:0] waitCnt, waitCntNext;
  logic [5:0] reqAddr;
  logic       lastShift;
  logic       shiftStep;

  assign reqAddr   = {inGlyph, inRow};
  assign lastShift = (state == SHIFT) && (pixCnt == LAST_CNT);
`ifdef CHAR_SCALE2_EN
  assign shiftStep = pixCnt[0];
`else
  assign shiftStep = 1'b1;
`endif

  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state     <= IDLE;
      romAddr   <= '0;
      pendAddr  <= '0;
      pendValid <= 1'b0;
      overflow  <= 1'b0;
      shiftReg  <= '0;
      pixCnt    <= '0;
      waitCnt   <= '0;
    end else begin
      state     <= stateNext;
      romAddr   <= romAddrNext;
      pendAddr  <= pendAddrNext;
      pendValid <= pendValidNext;
      overflow  <= overflowNext;
      shiftReg  <= shiftRegNext;
      pixCnt    <= pixCntNext;
      waitCnt   <= waitCntNext;
    end
  end

  always_comb begin
    stateNext     = state;
    romAddrNext   = romAddr;
    pendAddrNext  = pendAddr;
    pendValidNext = pendValid;
    overflowNext  = overflow;
    shiftRegNext  = shiftReg;
    pixCntNext    = pixCnt;
    waitCntNext   = waitCnt;

    case (state)
      IDLE: begin
        if (inStart) begin
          romAddrNext = reqAddr;
          stateNext   = FETCH;
        end
      end
      FETCH: begin
        waitCntNext = '0;
        stateNext   = WAIT;
      end
      WAIT: begin
        if (waitCnt == LAST_WAIT) begin
          shiftRegNext = inRomData;
          pixCntNext   = '0;
          stateNext    = SHIFT;
        end else begin
          waitCntNext = waitCnt + 2'd1;
        end
      end
      SHIFT: begin
        pixCntNext = pixCnt + 4'd1;
        if (shiftStep) shiftRegNext = {shiftReg[6:0], 1'b0};
        if (lastShift) begin
          // The pending entry wins; a coincident request refills the freed slot.
          if (pendValid) begin
            romAddrNext   = pendAddr;
            stateNext     = FETCH;
            pendValidNext = inStart;
            if (inStart) pendAddrNext = reqAddr;
          end else if (inStart) begin
            romAddrNext = reqAddr;
            stateNext   = FETCH;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    if ((state != IDLE) && !lastShift && inStart) begin
      if (!pendValid) begin
        pendValidNext = 1'b1;
        pendAddrNext  = reqAddr;
      end else begin
        overflowNext = 1'b1;
      end
    end
  end

  assign outRomAddress = romAddr;
  assign outPixelValid = (state == SHIFT);
  assign outPixel      = outPixelValid & shiftReg[7];
  assign outLast       = (state == SHIFT) && (pixCnt >= LAST_PIX_CNT);
  assign outBusy       = (state != IDLE);
  assign outReady      = !pendValid;
  assign outOverflow   = overflow;

endmodule

// File: tb/tb_char_row_sequencer.sv
// tb/tb_char_row_sequencer.sv - directed bench for char_row_sequencer (ROM_LATENCY 1 and 2)
module tb_char_row_sequencer;

`ifdef CHAR_SCALE2_EN
  localparam int HOLD = 2;
`else
  localparam int HOLD = 1;
`endif
  localparam int SHIFT_N = 8 * HOLD;
  localparam int ROW_END = 2 + SHIFT_N;

  logic       pixelClk = 1'b0;
  logic       reset = 1'b1;
  logic       inStart = 1'b0;
  logic       inStart2 = 1'b0;
  logic [1:0] inGlyph = '0;
  logic [3:0] inRow = '0;
  logic [5:0] outRomAddress, outRomAddress2;
  logic [7:0] inRomData, inRomData2, romA2;
  logic       outPixel, outPixelValid, outLast, outBusy, outReady, outOverflow;
  logic       outPixel2, outPixelValid2, outLast2, outBusy2, outReady2, outOverflow2;
  int         total = 0;
  int         bad = 0;

  always #5 pixelClk = ~pixelClk;

  char_row_sequencer #(.ROM_LATENCY(1)) dut (
    .pixelClk(pixelClk), .reset(reset), .inStart(inStart), .inGlyph(inGlyph), .inRow(inRow),
    .outRomAddress(outRomAddress), .inRomData(inRomData), .outPixel(outPixel),
    .outPixelValid(outPixelValid), .outLast(outLast), .outBusy(outBusy),
    .outReady(outReady), .outOverflow(outOverflow));

  char_row_sequencer #(.ROM_LATENCY(2)) dut2 (
    .pixelClk(pixelClk), .reset(reset), .inStart(inStart2), .inGlyph(inGlyph), .inRow(inRow),
    .outRomAddress(outRomAddress2), .inRomData(inRomData2), .outPixel(outPixel2),
    .outPixelValid(outPixelValid2), .outLast(outLast2), .outBusy(outBusy2),
    .outReady(outReady2), .outOverflow(outOverflow2));

  function automatic logic [7:0] romLookup(input logic [5:0] a);
    case (a)
      6'h11:   return 8'hFE;
      6'h37:   return 8'hFF;
      6'h03:   return 8'hEC;
      6'h25:   return 8'hC6;
      6'h0A:   return 8'h3C;
      default: return {2'b10, a};
    endcase
  endfunction

  always_ff @(posedge pixelClk) begin
    inRomData  <= romLookup(outRomAddress);
    romA2      <= romLookup(outRomAddress2);
    inRomData2 <= romA2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge pixelClk);
      #1;
      inStart  = 1'b0;
      inStart2 = 1'b0;
    end
  endtask

  task automatic start(input logic [1:0] g, input logic [3:0] r);
    inGlyph = g;
    inRow   = r;
    inStart = 1'b1;
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, ".addr"}, outRomAddress, 0);
    check({tag, ".pix"}, outPixel, 0);
    check({tag, ".valid"}, outPixelValid, 0);
    check({tag, ".last"}, outLast, 0);
    check({tag, ".busy"}, outBusy, 0);
    check({tag, ".ready"}, outReady, 1);
    check({tag, ".ovf"}, outOverflow, 0);
  endtask

  // Checks one full row starting at the current cycle; returns one cycle after it.
  task automatic checkRow(input string tag, input logic [7:0] data);
    logic [7:0] d;
    d = data;
    for (int i = 0; i < SHIFT_N; i++) begin
      check($sformatf("%s.valid%0d", tag, i), outPixelValid, 1);
      check($sformatf("%s.pix%0d", tag, i), outPixel, d[7 - i / HOLD]);
      check($sformatf("%s.last%0d", tag, i), outLast, (i >= SHIFT_N - HOLD) ? 1 : 0);
      tick();
    end
  endtask

  initial begin
    tick(2);
    checkResetValues("rst");
    reset = 1'b0;
    tick();

    // single row, glyph 1 row 1
    start(2'd1, 4'd1);
    tick();
    check("a.addr", outRomAddress, 6'h11);
    check("a.busy", outBusy, 1);
    check("a.valid1", outPixelValid, 0);
    tick();
    check("a.valid2", outPixelValid, 0);
    tick();
    checkRow("a", 8'hFE);
    check("a.busyEnd", outBusy, 0);
    check("a.validEnd", outPixelValid, 0);
    tick(2);

    // queued second row with 2-cycle gap
    start(2'd3, 4'd7);
    tick(3);
    start(2'd0, 4'd3);
    checkRow("b0", 8'hFF);
    check("b.gapValid0", outPixelValid, 0);
    check("b.gapAddr", outRomAddress, 6'h03);
    check("b.gapReady", outReady, 1);
    tick();
    check("b.gapValid1", outPixelValid, 0);
    tick();
    checkRow("b1", 8'hEC);
    check("b.busyEnd", outBusy, 0);
    check("b.ovf", outOverflow, 0);
    tick(2);

    // queue + two overflows
    start(2'd2, 4'd5);
    tick(3);
    start(2'd0, 4'd10);
    tick();
    check("c.ready1", outReady, 0);
    check("c.ovf1", outOverflow, 0);
    start(2'd3, 4'd15);
    tick();
    check("c.ovf2", outOverflow, 1);
    check("c.ready2", outReady, 0);
    start(2'd1, 4'd2);
    tick();
    check("c.ovf3", outOverflow, 1);
    tick(ROW_END + 1 - 6);
    check("c.addr", outRomAddress, 6'h0A);
    check("c.valid", outPixelValid, 0);
    tick(2);
    checkRow("c1", 8'h3C);
    check("c.busyEnd", outBusy, 0);
    tick(5);
    check("c.ovfSticky", outOverflow, 1);
    check("c.idle", outBusy, 0);

    // direct take during last SHIFT cycle
    start(2'd1, 4'd1);
    tick(ROW_END);
    check("e.last", outLast, 1);
    start(2'd3, 4'd7);
    tick();
    check("e.addr", outRomAddress, 6'h37);
    check("e.ready", outReady, 1);
    check("e.ovf", outOverflow, 1);
    tick(2);
    checkRow("e1", 8'hFF);
    check("e.busyEnd", outBusy, 0);

    // reset mid-row, coincident start ignored
    start(2'd2, 4'd5);
    tick(3 + 3 * HOLD);
    check("d.pix4", outPixel, 0);
    check("d.valid4", outPixelValid, 1);
    reset = 1'b1;
    start(2'd1, 4'd1);
    tick();
    checkResetValues("d");
    reset = 1'b0;
    tick();
    check("d.stillIdle", outBusy, 0);
    start(2'd1, 4'd1);
    tick(3);
    checkRow("d1", 8'hFE);

    // ROM_LATENCY = 2 instance
    inGlyph  = 2'd1;
    inRow    = 4'd1;
    inStart2 = 1'b1;
    tick();
    check("l2.addr", outRomAddress2, 6'h11);
    tick(2);
    check("l2.valid3", outPixelValid2, 0);
    check("l2.busy3", outBusy2, 1);
    tick();
    check("l2.valid4", outPixelValid2, 1);
    check("l2.pix4", outPixel2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
